// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU and PC-source
// selections, FSM state codes and the instruction class used by the decoder.
package ctrl_pkg;

    localparam logic [3:0] OP_JAL  = 4'b0000;
    localparam logic [3:0] OP_JALR = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BLE  = 4'b0011;
    localparam logic [3:0] OP_LB   = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_ANDI = 4'b1110;
    localparam logic [3:0] OP_ORI  = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_BEQ = 3'd4;
    localparam logic [2:0] ALU_BLE = 3'd5;

    localparam logic [1:0] PC_INC = 2'd0;  // PC+2
    localparam logic [1:0] PC_REL = 2'd1;  // PC+imm
    localparam logic [1:0] PC_REG = 2'd2;  // rs1+imm

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_JUMP
    } op_class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: IR/ALU/memory inputs and the datapath control outputs.
// master = control unit, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic               mreq;
    logic               ir_we;
    logic               pc_we;
    logic [1:0]         PCsrc;
    logic               m2reg;
    logic               wmem;
    logic               memc;
    logic               alucsrc;
    logic               wreg;
    logic               jal;
    logic [ALUOP_W-1:0] ALUOp;
    logic               instr_done;
    logic               err;

    modport master (
        input  op, zero, mem_ready,
        output mreq, ir_we, pc_we, PCsrc, m2reg, wmem, memc, alucsrc,
               wreg, jal, ALUOp, instr_done, err
    );

    modport slave (
        output op, zero, mem_ready,
        input  mreq, ir_we, pc_we, PCsrc, m2reg, wmem, memc, alucsrc,
               wreg, jal, ALUOp, instr_done, err
    );
endinterface

// File: rtl/op_decoder.sv
// Combinational opcode decode: ALU operation, operand-B select, memory width
// and the instruction class that steers the FSM.
module op_decoder
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               alucsrc_o,
    output logic               memc_o,
    output logic               jalr_o,
    output op_class_e          cls_o
);
    logic [3:0] opc;
    assign opc = 4'(op_i);

    always_comb begin
        aluop_o   = ALUOP_W'(ALU_ADD);
        alucsrc_o = 1'b0;
        memc_o    = 1'b0;
        jalr_o    = 1'b0;
        cls_o     = CL_ALU;
        case (opc)
            OP_JAL:  cls_o = CL_JUMP;
            OP_JALR: begin
                cls_o     = CL_JUMP;
                jalr_o    = 1'b1;
                alucsrc_o = 1'b1;
            end
            OP_BEQ: begin
                cls_o   = CL_BRANCH;
                aluop_o = ALUOP_W'(ALU_BEQ);
            end
            OP_BLE: begin
                cls_o   = CL_BRANCH;
                aluop_o = ALUOP_W'(ALU_BLE);
            end
            OP_LB: begin
                cls_o     = CL_LOAD;
                alucsrc_o = 1'b1;
            end
            OP_LW: begin
                cls_o     = CL_LOAD;
                alucsrc_o = 1'b1;
                memc_o    = 1'b1;
            end
            OP_SB: begin
                cls_o     = CL_STORE;
                alucsrc_o = 1'b1;
            end
            OP_SW: begin
                cls_o     = CL_STORE;
                alucsrc_o = 1'b1;
                memc_o    = 1'b1;
            end
            OP_ADD:  aluop_o = ALUOP_W'(ALU_ADD);
            OP_SUB:  aluop_o = ALUOP_W'(ALU_SUB);
            OP_AND:  aluop_o = ALUOP_W'(ALU_AND);
            OP_OR:   aluop_o = ALUOP_W'(ALU_OR);
            OP_ADDI: begin
                aluop_o   = ALUOP_W'(ALU_ADD);
                alucsrc_o = 1'b1;
            end
            OP_SUBI: begin
                aluop_o   = ALUOP_W'(ALU_SUB);
                alucsrc_o = 1'b1;
            end
            OP_ANDI: begin
                aluop_o   = ALUOP_W'(ALU_AND);
                alucsrc_o = 1'b1;
            end
            OP_ORI: begin
                aluop_o   = ALUOP_W'(ALU_OR);
                alucsrc_o = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/ERROR) with a memory-ready
// timeout that parks the unit in a sticky ERROR state until reset.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);
    logic [2:0]         state_q, state_d;
    logic [OP_W-1:0]    op_q;
    logic [TO_W-1:0]    cnt_q, cnt_d;

    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_alucsrc;
    logic               dec_memc;
    logic               dec_jalr;
    op_class_e          dec_cls;

    op_decoder #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .op_i      (op_q),
        .aluop_o   (dec_aluop),
        .alucsrc_o (dec_alucsrc),
        .memc_o    (dec_memc),
        .jalr_o    (dec_jalr),
        .cls_o     (dec_cls)
    );

    logic            mem_wait;
    logic [TO_W:0]   cnt_inc;
    logic            to_hit;

    // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a ready in that same cycle still wins because it is tested first below.
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign to_hit   = (MEM_TIMEOUT != 0) && (cnt_inc == (TO_W + 1)'(MEM_TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (to_hit)    state_d = S_ERROR;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (dec_cls == CL_BRANCH)
                    state_d = S_FETCH;
                else if ((dec_cls == CL_LOAD) || (dec_cls == CL_STORE))
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready)  state_d = (dec_cls == CL_STORE) ? S_FETCH : S_WB;
                else if (to_hit)    state_d = S_ERROR;
            end
            S_WB:    state_d = S_FETCH;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (mem_wait)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE)
                op_q <= bus.op;
        end
    end

    always_comb begin
        bus.mreq       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.PCsrc      = PC_INC;
        bus.m2reg      = 1'b0;
        bus.wmem       = 1'b0;
        bus.memc       = 1'b0;
        bus.alucsrc    = 1'b0;
        bus.wreg       = 1'b0;
        bus.jal        = 1'b0;
        bus.ALUOp      = '0;
        bus.instr_done = 1'b0;
        bus.err        = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mreq  = 1'b1;
                    bus.ir_we = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.ALUOp   = dec_aluop;
                    bus.alucsrc = dec_alucsrc;
                    bus.memc    = dec_memc;
                    if (dec_cls == CL_BRANCH) begin
                        bus.pc_we      = 1'b1;
                        bus.instr_done = 1'b1;
                        bus.PCsrc      = bus.zero ? PC_INC : PC_REL;
                    end
                end
                S_MEM: begin
                    bus.mreq    = 1'b1;
                    bus.ALUOp   = dec_aluop;
                    bus.alucsrc = dec_alucsrc;
                    bus.memc    = dec_memc;
                    if (dec_cls == CL_STORE) begin
                        bus.wmem       = 1'b1;
                        bus.pc_we      = bus.mem_ready;
                        bus.instr_done = bus.mem_ready;
                    end
                end
                S_WB: begin
                    bus.ALUOp      = dec_aluop;
                    bus.alucsrc    = dec_alucsrc;
                    bus.memc       = dec_memc;
                    bus.wreg       = 1'b1;
                    bus.pc_we      = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.m2reg      = (dec_cls == CL_LOAD);
                    if (dec_cls == CL_JUMP) begin
                        bus.jal   = 1'b1;
                        bus.PCsrc = dec_jalr ? PC_REG : PC_REL;
                    end
                end
                S_ERROR: bus.err = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle successor to the single-cycle control unit of the 16-bit CPU. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, waits on a memory ready handshake, and issues exactly one PC write per instruction. It adds a bounded memory timeout with a sticky error state. It sits between the instruction register/ALU `zero` flag and the datapath muxes, register file, and data memory.

## Interface
Parameters:
- `OP_W`, 4: opcode width.
- `ALUOP_W`, 3: ALUOp width.
- `MEM_TIMEOUT`, 15: maximum consecutive `mem_ready`-low cycles in FETCH or MEM before ERROR. 0 disables the timeout.
- `TO_W`, 4: timeout counter width. Must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- `clk` in 1: clock. The block uses one clock.
- `rst` in 1: reset, synchronous, active-high.
- `op` in OP_W: opcode field of the IR. Valid from DECODE onward.
- `zero` in 1: ALU zero/compare flag. Sampled in EXEC.
- `mem_ready` in 1: memory access completes this cycle.
- `mreq` out 1: memory request (FETCH, and MEM for loads/stores).
- `ir_we` out 1: IR load strobe.
- `pc_we` out 1: PC write strobe.
- `PCsrc` out 2: 0 = PC+2, 1 = PC+imm, 2 = rs1+imm.
- `m2reg`, `wmem`, `memc`, `alucsrc`, `wreg`, `jal` out 1 each: same meaning as in the single-cycle unit.
- `ALUOp` out ALUOP_W: 0 add, 1 sub, 2 and, 3 or, 4 beq, 5 ble.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `err` out 1: sticky memory-timeout error.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, ERROR. Encode them in 3 bits.
- FETCH: drive `mreq`=1. When `mem_ready`=1, also drive `ir_we`=1 and go to DECODE.
- DECODE: latch `op` into `op_q`, then go to EXEC. All later outputs decode from `op_q`.
- EXEC: drive `ALUOp`/`alucsrc` per `op_q`. The next state depends on the instruction class:
  - Branches (beq, ble): taken when `zero`=0. Drive `pc_we`=1, with `PCsrc`=1 if taken and 0 otherwise. Pulse `instr_done` and go to FETCH.
  - Loads/stores: go to MEM.
  - All other instructions: go to WB.
- MEM: drive `mreq`=1.
  - Stores: hold `wmem`=1 and `memc` for the whole state. On `mem_ready`, drive `pc_we`=1, `PCsrc`=0, pulse `instr_done`, and go to FETCH.
  - Loads: on `mem_ready`, go to WB.
- WB: drive `wreg`=1, `pc_we`=1, pulse `instr_done`, then go to FETCH.
  - Loads: `m2reg`=1.
  - jal: `jal`=1, `PCsrc`=1.
  - jalr: `jal`=1, `PCsrc`=2.
  - All others: `PCsrc`=0.
- Per-op ALU fields:
  - add/addi: ALUOp 0. sub/subi: 1. and/andi: 2. or/ori: 3.
  - Immediate forms, jalr, and loads/stores: `alucsrc`=1.
  - lb/sb: `memc`=0. lw/sw: `memc`=1.
- Strobes (`mreq`, `ir_we`, `pc_we`, `wmem`, `wreg`, `instr_done`) are 0 in every state and condition not listed above.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle in FETCH or MEM while `mem_ready`=0.
  - When it equals MEM_TIMEOUT (and MEM_TIMEOUT≠0), go to ERROR instead of waiting further.
- ERROR: `err`=1, all strobes 0. The block stays in ERROR until `rst`.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset: while `rst`=1 at a clock edge, the next state is FETCH, `op_q`=0, counter=0, and `err`=0.
- All outputs are gated to 0 while `rst` is high. The first `mreq` appears in the cycle after `rst` deasserts.
- Outputs are combinational from state, `op_q`, `zero` (EXEC only), and `mem_ready`. There are no registered-output delays.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - ALU, immediate, jal, jalr: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle in FETCH or MEM adds 1 cycle.
- Exactly one `pc_we` pulse and one `instr_done` pulse occur per instruction, in the same cycle.
- `rst` asserted mid-instruction aborts it. No `pc_we` or `wreg` is issued on the reset cycle.
- Timeout boundary: `mem_ready`=1 arriving on the cycle the counter reaches MEM_TIMEOUT still completes the access normally. A ready has priority over the timeout.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode localparams: jal 0000 … ori 1111.
  - ALUOp encodings.
  - PCsrc encodings.
  - The state encoding.
- Sub-module `op_decoder`: purely combinational `op_q` → {ALUOp, alucsrc, memc, class (branch/load/store/jump/alu)}.
- The top level holds the FSM, `op_q`, and the timeout counter, and gates the decoder fields by state.

## Test plan
- add (op 1000), `mem_ready` tied 1 → `ir_we` at cycle 0, `wreg`=`pc_we`=`instr_done`=1 at cycle 3, `PCsrc`=0, ALUOp=0.
- beq with `zero`=0 in EXEC → `pc_we`=1, `PCsrc`=1 at cycle 2. Repeat with `zero`=1 → `PCsrc`=0. Neither case asserts `wreg`.
- lw with `mem_ready` low for 3 cycles in MEM → `mreq` held, completes in 8 cycles total, WB shows `m2reg`=1, `wreg`=1, `memc`=1.
- sw with `mem_ready` low forever, MEM_TIMEOUT=15 → `wmem` high for 15 cycles, then ERROR with `err`=1 and strobes 0. Then `rst` → `err`=0 and FETCH resumes.
- jalr, then `rst` pulsed during EXEC → no `pc_we`/`wreg` on the reset cycle, FETCH on the following cycle. A rerun without reset shows WB `PCsrc`=2, `jal`=1, `wreg`=1.
- `mem_ready`=1 exactly on the timeout cycle in FETCH → `ir_we`=1, transition to DECODE, `err` stays 0.
